// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker.
package mouse_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DELTA_W = 9;

    // Status byte bit positions
    localparam int unsigned LEFT  = 0;
    localparam int unsigned RIGHT = 1;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XSIGN = 4;
    localparam int unsigned YSIGN = 5;
    localparam int unsigned XOVF  = 6;
    localparam int unsigned YOVF  = 7;

    typedef enum logic [1:0] {
        ST_STATUS = 2'd0,
        ST_DX     = 2'd1,
        ST_DY     = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Status bits retained between the status byte and the update cycle
    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ysign;
        logic xsign;
        logic right;
        logic left;
    } pkt_status_t;

endpackage

// File: rtl/mouse_axis_accum.sv
// One axis of the tracker: applies a signed 9-bit delta to the current
// coordinate and clamps the result into 0..MAX.
module mouse_axis_accum
    import mouse_pkg::*;
#(
    parameter int unsigned MAX = 639
) (
    input  logic [COORD_W-1:0] i_cur,
    input  logic [DELTA_W-1:0] i_delta,
    input  logic               i_ovf,
    input  logic               i_invert,
    output logic [COORD_W-1:0] o_next_c
);

    localparam int unsigned SUM_W = 17;

    logic signed [SUM_W-1:0] w_cur;
    logic signed [SUM_W-1:0] w_delta;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_max;

    // Sign-extend, add (or subtract for the inverted Y axis), then clamp
    always_comb begin
        w_cur    = $signed({1'b0, i_cur});
        w_delta  = $signed({{(SUM_W-DELTA_W){i_delta[DELTA_W-1]}}, i_delta});
        w_max    = $signed(SUM_W'(MAX));
        w_sum    = i_invert ? (w_cur - w_delta) : (w_cur + w_delta);
        o_next_c = i_cur;
        if (!i_ovf) begin
            if (w_sum < 0) begin
                o_next_c = '0;
            end else if (w_sum > w_max) begin
                o_next_c = COORD_W'(MAX);
            end else begin
                o_next_c = w_sum[COORD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mouse_tracker.sv
// PS/2 mouse packet decoder: assembles 3-byte packets from a valid/ready
// byte stream and maintains clamped absolute coordinates and button levels.
module mouse_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned X_MAX   = 639,
    parameter int unsigned Y_MAX   = 479,
    parameter int unsigned INIT_X  = 320,
    parameter int unsigned INIT_Y  = 240,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset_,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    output logic [COORD_W-1:0] mouse_x,
    output logic [COORD_W-1:0] mouse_y,
    output logic               mouse_pressed_,
    output logic               mouse_right_pressed,
    output logic               packet_strobe,
    output logic               sync_error
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    pkt_status_t         r_status;
    logic [BYTE_W-1:0]   r_dx;
    logic [BYTE_W-1:0]   r_dy;
    logic [IDLE_W-1:0]   r_idle;
    logic [COORD_W-1:0]  r_x;
    logic [COORD_W-1:0]  r_y;
    logic                r_left;
    logic                r_right;
    logic                r_strobe;
    logic                r_sync_err;
    logic                r_ready;

    state_t              w_state_nxt;
    logic [IDLE_W-1:0]   w_idle_nxt;
    logic                w_xfer;
    logic                w_cap_status;
    logic                w_cap_dx;
    logic                w_cap_dy;
    logic                w_drop;
    logic                w_timeout;
    logic [COORD_W-1:0]  w_x_next;
    logic [COORD_W-1:0]  w_y_next;

    assign w_xfer = in_valid & r_ready;

    // Next-state, byte capture strobes and idle timeout
    always_comb begin
        w_state_nxt  = r_state;
        w_idle_nxt   = '0;
        w_cap_status = 1'b0;
        w_cap_dx     = 1'b0;
        w_cap_dy     = 1'b0;
        w_drop       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_STATUS: begin
                if (w_xfer) begin
                    if (in_data[SYNC]) begin
                        w_cap_status = 1'b1;
                        w_state_nxt  = ST_DX;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ST_DX, ST_DY: begin
                if (w_xfer) begin
                    w_cap_dx    = (r_state == ST_DX);
                    w_cap_dy    = (r_state == ST_DY);
                    w_state_nxt = (r_state == ST_DX) ? ST_DY : ST_UPDATE;
                end else if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_STATUS;
                end else begin
                    w_idle_nxt = r_idle + IDLE_W'(1);
                end
            end
            ST_UPDATE: begin
                w_state_nxt = ST_STATUS;
            end
            default: begin
                w_state_nxt = ST_STATUS;
            end
        endcase
    end

    mouse_axis_accum #(
        .MAX (X_MAX)
    ) u_axis_x (
        .i_cur    (r_x),
        .i_delta  ({r_status.xsign, r_dx}),
        .i_ovf    (r_status.xovf),
        .i_invert (1'b0),
        .o_next_c (w_x_next)
    );

    mouse_axis_accum #(
        .MAX (Y_MAX)
    ) u_axis_y (
        .i_cur    (r_y),
        .i_delta  ({r_status.ysign, r_dy}),
        .i_ovf    (r_status.yovf),
        .i_invert (1'b1),
        .o_next_c (w_y_next)
    );

    // State, captured bytes, coordinates and pulse outputs
    always_ff @(posedge clock) begin
        if (reset_) begin
            r_state    <= ST_STATUS;
            r_status   <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_idle     <= '0;
            r_x        <= COORD_W'(INIT_X);
            r_y        <= COORD_W'(INIT_Y);
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_strobe   <= 1'b0;
            r_sync_err <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_idle     <= w_idle_nxt;
            r_ready    <= (w_state_nxt != ST_UPDATE);
            r_strobe   <= (r_state == ST_UPDATE);
            r_sync_err <= w_drop | w_timeout;
            if (w_cap_status) begin
                r_status <= '{yovf:  in_data[YOVF],
                              xovf:  in_data[XOVF],
                              ysign: in_data[YSIGN],
                              xsign: in_data[XSIGN],
                              right: in_data[RIGHT],
                              left:  in_data[LEFT]};
            end
            if (w_cap_dx) begin
                r_dx <= in_data;
            end
            if (w_cap_dy) begin
                r_dy <= in_data;
            end
            if (r_state == ST_UPDATE) begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_left  <= r_status.left;
                r_right <= r_status.right;
            end
        end
    end

    assign in_ready            = r_ready;
    assign mouse_x             = r_x;
    assign mouse_y             = r_y;
    assign mouse_pressed_      = r_left;
    assign mouse_right_pressed = r_right;
    assign packet_strobe       = r_strobe;
    assign sync_error          = r_sync_err;

endmodule

// File: tb/tb_mouse_tracker.sv
// Scoreboard bench for mouse_tracker: stimulus pushes expected events,
// a negedge monitor pops and compares on every strobe or sync_error pulse.
module tb_mouse_tracker;

    logic        clock;
    logic        reset_;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] mouse_x;
    logic [15:0] mouse_y;
    logic        mouse_pressed_;
    logic        mouse_right_pressed;
    logic        packet_strobe;
    logic        sync_error;

    typedef struct packed {
        logic        is_sync;
        logic [15:0] x;
        logic [15:0] y;
        logic        left;
        logic        right;
    } exp_t;

    exp_t q[$];
    exp_t got;
    exp_t want;
    int   checks   = 0;
    int   failures = 0;

    mouse_tracker dut (
        .clock               (clock),
        .reset_              (reset_),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .mouse_x             (mouse_x),
        .mouse_y             (mouse_y),
        .mouse_pressed_      (mouse_pressed_),
        .mouse_right_pressed (mouse_right_pressed),
        .packet_strobe       (packet_strobe),
        .sync_error          (sync_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: every output event must match the oldest expectation
    always @(negedge clock) begin
        if (!reset_ && (packet_strobe || sync_error)) begin
            checks++;
            got = '{is_sync: sync_error, x: mouse_x, y: mouse_y,
                    left: mouse_pressed_, right: mouse_right_pressed};
            if (packet_strobe && sync_error) begin
                failures++;
                $display("FAIL both_pulses strobe and sync_error together at %0t", $time);
            end else if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event sync=%0b x=%0d y=%0d l=%0b r=%0b at %0t",
                         got.is_sync, got.x, got.y, got.left, got.right, $time);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL event got sync=%0b x=%0d y=%0d l=%0b r=%0b want sync=%0b x=%0d y=%0d l=%0b r=%0b",
                             got.is_sync, got.x, got.y, got.left, got.right,
                             want.is_sync, want.x, want.y, want.left, want.right);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout byte=%02h", b);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while (q.size() != 0 && n < lim) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", q.size());
            q.delete();
        end
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int ex, input int ey, input logic el, input logic er);
        q.push_back('{is_sync: 1'b0, x: 16'(ex), y: 16'(ey), left: el, right: er});
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        chk("ready_low_in_update", 16'(in_ready), 16'd0);
        wait_drain(20);
    endtask

    task automatic do_reset();
        reset_ = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_ = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"},     mouse_x, 16'd320);
        chk({tag, "_y"},     mouse_y, 16'd240);
        chk({tag, "_left"},  16'(mouse_pressed_), 16'd0);
        chk({tag, "_right"}, 16'(mouse_right_pressed), 16'd0);
        chk({tag, "_ready"}, 16'(in_ready), 16'd1);
        chk({tag, "_pulses"}, 16'({packet_strobe, sync_error}), 16'd0);
    endtask

    initial begin
        reset_   = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        reset_ = 1'b0;

        // Reset state, then idle
        chk_reset_vals("rst");
        repeat (10) @(negedge clock);
        chk_reset_vals("idle");

        // Basic packet: left, dx=+10, dy=+5 (Y inverted)
        send_pkt(8'h09, 8'h0A, 8'h05, 330, 235, 1'b1, 1'b0);

        // Clamp at 0 on Y, then move Y back down by 255
        do_reset();
        send_pkt(8'h18, 8'h00, 8'hFF, 64, 0, 1'b0, 1'b0);
        send_pkt(8'h28, 8'h00, 8'h01, 64, 255, 1'b0, 1'b0);

        // Drive X into the upper clamp, then overflow packets
        do_reset();
        send_pkt(8'h08, 8'hFF, 8'h00, 575, 240, 1'b0, 1'b0);
        send_pkt(8'h08, 8'hFF, 8'h00, 639, 240, 1'b0, 1'b0);
        send_pkt(8'h08, 8'hFF, 8'h00, 639, 240, 1'b0, 1'b0);
        send_pkt(8'h49, 8'h7F, 8'h00, 639, 240, 1'b1, 1'b0);
        send_pkt(8'h88, 8'h00, 8'h50, 639, 240, 1'b0, 1'b0);

        // Unsynchronised byte dropped, then a right-button packet
        do_reset();
        q.push_back('{is_sync: 1'b1, x: 16'd320, y: 16'd240, left: 1'b0, right: 1'b0});
        send_byte(8'h00);
        wait_drain(20);
        send_pkt(8'h0A, 8'h01, 8'h00, 321, 240, 1'b0, 1'b1);

        // Mid-packet stall: no pulse for 1000 idle cycles, then timeout
        send_byte(8'h08);
        send_byte(8'h10);
        repeat (1000) @(negedge clock);
        q.push_back('{is_sync: 1'b1, x: 16'd321, y: 16'd240, left: 1'b0, right: 1'b1});
        wait_drain(100);
        send_pkt(8'h09, 8'h05, 8'h03, 326, 237, 1'b1, 1'b0);

        // Transfer one cycle before the timeout would fire is accepted
        q.push_back('{is_sync: 1'b0, x: 16'd328, y: 16'd237, left: 1'b0, right: 1'b0});
        send_byte(8'h08);
        send_byte(8'h02);
        repeat (1022) @(negedge clock);
        send_byte(8'h00);
        wait_drain(20);

        // Reset mid-packet discards the partial packet
        send_byte(8'h08);
        send_byte(8'h10);
        reset_ = 1'b1;
        @(negedge clock);
        chk_reset_vals("midrst");
        reset_ = 1'b0;
        send_pkt(8'h09, 8'h0A, 8'h05, 330, 235, 1'b1, 1'b0);

        repeat (5) @(negedge clock);
        chk("queue_empty", 16'(q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
